// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and the ID/EX control bundle for the five-stage pipeline
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int ALUOP_W = 3;
  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic memToReg;
    logic aluSrc;
    logic regDst;
    logic [ALUOP_W-1:0] aluOp;
  } idex_ctrl_t;
  localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '0;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: combinational load-use hazard check between the ID instruction and the load in ID/EX
module load_use_detector #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             IDEX_Valid,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_RegisterRt,
  input  logic [REG_W-1:0] ID_RegisterRs,
  input  logic [REG_W-1:0] ID_RegisterRt,
  input  logic             ID_UsesRt,
  input  logic             Flush,
  output logic             HazardStall
);
  logic loadPending;
  logic srcMatch;
  // A real load targeting a non-zero register whose result the ID instruction reads; a flushed ID instruction never stalls
  always_comb begin
    loadPending = IDEX_Valid && IDEX_MemRead && (IDEX_RegisterRt != '0);
    srcMatch = (IDEX_RegisterRt == ID_RegisterRs) || (ID_UsesRt && (IDEX_RegisterRt == ID_RegisterRt));
    HazardStall = !Flush && loadPending && srcMatch;
  end
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with bubble/flush/stall control; load-use detection under LOAD_USE_STALL_EN
module id_ex_register
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               ID_UsesRt,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PC4,
  input  logic [REG_W-1:0]   ID_RegisterRs,
  input  logic [REG_W-1:0]   ID_RegisterRt,
  input  logic [REG_W-1:0]   ID_RegisterRd,
  input  logic               Flush,
  input  logic               Stall,
  output logic               IDEX_RegWrite,
  output logic               IDEX_MemRead,
  output logic               IDEX_MemWrite,
  output logic               IDEX_MemToReg,
  output logic               IDEX_ALUSrc,
  output logic               IDEX_RegDst,
  output logic [ALUOP_W-1:0] IDEX_ALUOp,
  output logic [DATA_W-1:0]  IDEX_ReadData1,
  output logic [DATA_W-1:0]  IDEX_ReadData2,
  output logic [DATA_W-1:0]  IDEX_Imm,
  output logic [DATA_W-1:0]  IDEX_PC4,
  output logic [REG_W-1:0]   IDEX_RegisterRs,
  output logic [REG_W-1:0]   IDEX_RegisterRt,
  output logic [REG_W-1:0]   IDEX_RegisterRd,
  output logic               IDEX_Valid,
  output logic               HazardStall
);
  idex_ctrl_t ctrlIn;
  idex_ctrl_t ctrlQ;
  logic hazard;
  logic bubble;
`ifdef LOAD_USE_STALL_EN
  load_use_detector #(.REG_W(REG_W)) uDetector (
    .IDEX_Valid(IDEX_Valid),
    .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegisterRt(IDEX_RegisterRt),
    .ID_RegisterRs(ID_RegisterRs),
    .ID_RegisterRt(ID_RegisterRt),
    .ID_UsesRt(ID_UsesRt),
    .Flush(Flush),
    .HazardStall(hazard)
  );
`else
  logic unusedUsesRt;
  assign unusedUsesRt = ID_UsesRt;
  assign hazard = 1'b0;
`endif
  assign HazardStall = hazard;
  // Bundle the decoded controls and unpack the registered copy onto the EX-facing ports
  always_comb begin
    ctrlIn = '{regWrite: ID_RegWrite, memRead: ID_MemRead, memWrite: ID_MemWrite, memToReg: ID_MemToReg,
               aluSrc: ID_ALUSrc, regDst: ID_RegDst, aluOp: ID_ALUOp};
    IDEX_RegWrite = ctrlQ.regWrite;
    IDEX_MemRead = ctrlQ.memRead;
    IDEX_MemWrite = ctrlQ.memWrite;
    IDEX_MemToReg = ctrlQ.memToReg;
    IDEX_ALUSrc = ctrlQ.aluSrc;
    IDEX_RegDst = ctrlQ.regDst;
    IDEX_ALUOp = ctrlQ.aluOp;
  end
  // Flush beats Stall, Stall beats a hazard bubble; zeroed specifiers keep the forwarding unit from matching a bubble
  assign bubble = rst || Flush || (!Stall && hazard);
  // Pipeline register: bubble, hold or load
  always_ff @(posedge clk) begin
    if (bubble) begin
      ctrlQ <= IDEX_CTRL_BUBBLE;
      IDEX_Valid <= 1'b0;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_Imm <= '0;
      IDEX_PC4 <= '0;
      IDEX_RegisterRs <= '0;
      IDEX_RegisterRt <= '0;
      IDEX_RegisterRd <= '0;
    end else if (!Stall) begin
      ctrlQ <= ctrlIn;
      IDEX_Valid <= 1'b1;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_Imm <= ID_Imm;
      IDEX_PC4 <= ID_PC4;
      IDEX_RegisterRs <= ID_RegisterRs;
      IDEX_RegisterRt <= ID_RegisterRt;
      IDEX_RegisterRd <= ID_RegisterRd;
    end
  end
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: randomized self-checking bench with a spec-level model of the ID/EX register (LOAD_USE_STALL_EN aware)
module tb_id_ex_register;
`ifdef LOAD_USE_STALL_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif
  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        aluSrc;
    logic        regDst;
    logic [2:0]  aluOp;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } rec_t;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  logic stall = 0;
  logic usesRt = 0;
  rec_t drv = '0;
  rec_t exp = '0;
  int nCmp = 0;
  int nErr = 0;
  logic oRegWrite, oMemRead, oMemWrite, oMemToReg, oALUSrc, oRegDst, oValid, hazardStall;
  logic [2:0] oALUOp;
  logic [31:0] oRd1, oRd2, oImm, oPc4;
  logic [4:0] oRs, oRt, oRd;
  always #5 clk = ~clk;
  id_ex_register dut (
    .clk(clk), .rst(rst),
    .ID_RegWrite(drv.regWrite), .ID_MemRead(drv.memRead), .ID_MemWrite(drv.memWrite),
    .ID_MemToReg(drv.memToReg), .ID_ALUSrc(drv.aluSrc), .ID_RegDst(drv.regDst), .ID_ALUOp(drv.aluOp),
    .ID_UsesRt(usesRt),
    .ID_ReadData1(drv.rd1), .ID_ReadData2(drv.rd2), .ID_Imm(drv.imm), .ID_PC4(drv.pc4),
    .ID_RegisterRs(drv.rs), .ID_RegisterRt(drv.rt), .ID_RegisterRd(drv.rd),
    .Flush(flush), .Stall(stall),
    .IDEX_RegWrite(oRegWrite), .IDEX_MemRead(oMemRead), .IDEX_MemWrite(oMemWrite),
    .IDEX_MemToReg(oMemToReg), .IDEX_ALUSrc(oALUSrc), .IDEX_RegDst(oRegDst), .IDEX_ALUOp(oALUOp),
    .IDEX_ReadData1(oRd1), .IDEX_ReadData2(oRd2), .IDEX_Imm(oImm), .IDEX_PC4(oPc4),
    .IDEX_RegisterRs(oRs), .IDEX_RegisterRt(oRt), .IDEX_RegisterRd(oRd),
    .IDEX_Valid(oValid), .HazardStall(hazardStall)
  );
  function automatic rec_t act();
    return '{valid: oValid, regWrite: oRegWrite, memRead: oMemRead, memWrite: oMemWrite, memToReg: oMemToReg,
             aluSrc: oALUSrc, regDst: oRegDst, aluOp: oALUOp, rd1: oRd1, rd2: oRd2, imm: oImm, pc4: oPc4,
             rs: oRs, rt: oRt, rd: oRd};
  endfunction
  // a load sitting in EX whose destination the ID instruction reads stalls, unless it targets $zero or ID is flushed
  function automatic logic modelHaz();
    if (!HAZ_EN || flush || !exp.valid || !exp.memRead || exp.rt == 0) return 1'b0;
    return (exp.rt == drv.rs) || (usesRt && exp.rt == drv.rt);
  endfunction
  function automatic rec_t rnd(int regMax);
    rec_t r;
    r.valid = 1'b0;
    r.regWrite = 1'($urandom);
    r.memRead = 1'($urandom);
    r.memWrite = 1'($urandom);
    r.memToReg = 1'($urandom);
    r.aluSrc = 1'($urandom);
    r.regDst = 1'($urandom);
    r.aluOp = 3'($urandom);
    r.rd1 = $urandom;
    r.rd2 = $urandom;
    r.imm = $urandom;
    r.pc4 = $urandom;
    r.rs = 5'($urandom_range(regMax));
    r.rt = 5'($urandom_range(regMax));
    r.rd = 5'($urandom_range(regMax));
    return r;
  endfunction
  // advance one clock and update the model from the priority rules
  task automatic tick();
    rec_t nxt;
    logic h;
    h = modelHaz();
    if (rst || flush || (!stall && h)) nxt = '0;
    else if (stall) nxt = exp;
    else begin
      nxt = drv;
      nxt.valid = 1'b1;
    end
    @(posedge clk);
    #1;
    exp = nxt;
  endtask
  task automatic test_reset();
    rst = 1;
    drv = rnd(31);
    usesRt = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nCmp++;
      if (act() !== rec_t'(0)) begin nErr++; $display("FAIL reset_outputs: got %h want 0", act()); end
      nCmp++;
      if (hazardStall !== 1'b0) begin nErr++; $display("FAIL reset_hazard: got %b want 0", hazardStall); end
    end
    rst = 0;
    drv = '0;
    drv.regWrite = 1;
    drv.rd = 5;
    drv.rd1 = 32'h1234;
    usesRt = 0;
    tick();
    nCmp++;
    if (oRegWrite !== 1'b1 || oRd !== 5'd5 || oRd1 !== 32'h1234 || oValid !== 1'b1)
      begin nErr++; $display("FAIL pass_through: got rw=%b rd=%0d rd1=%h v=%b want 1 5 1234 1", oRegWrite, oRd, oRd1, oValid); end
    nCmp++;
    if (act() !== exp) begin nErr++; $display("FAIL pass_through_all: got %h want %h", act(), exp); end
  endtask
  task automatic loadInstr(logic [4:0] dst);
    drv = rnd(31);
    drv.memRead = 1;
    drv.rt = dst;
    drv.rs = 5'd20;
    usesRt = 0;
    flush = 0;
    stall = 0;
    tick();
  endtask
  task automatic test_load_use_rs();
    loadInstr(5'd8);
    drv = rnd(31);
    drv.rs = 8;
    drv.rt = 3;
    #1;
    nCmp++;
    if (hazardStall !== HAZ_EN) begin nErr++; $display("FAIL lu_rs_hazard: got %b want %b", hazardStall, HAZ_EN); end
    tick();
    nCmp++;
    if (act() !== exp || oValid !== !HAZ_EN) begin nErr++; $display("FAIL lu_rs_bubble: got %h want %h", act(), exp); end
    nCmp++;
    if (hazardStall !== 1'b0) begin nErr++; $display("FAIL lu_rs_hazard_clear: got %b want 0", hazardStall); end
    tick();
    nCmp++;
    if (act() !== exp || oValid !== 1'b1 || oRs !== 5'd8) begin nErr++; $display("FAIL lu_rs_consumer: got %h want %h", act(), exp); end
  endtask
  task automatic test_load_use_rt();
    loadInstr(5'd9);
    drv = rnd(31);
    drv.rs = 1;
    drv.rt = 9;
    usesRt = 1;
    #1;
    nCmp++;
    if (hazardStall !== HAZ_EN) begin nErr++; $display("FAIL lu_rt_uses: got %b want %b", hazardStall, HAZ_EN); end
    usesRt = 0;
    #1;
    nCmp++;
    if (hazardStall !== 1'b0) begin nErr++; $display("FAIL lu_rt_not_used: got %b want 0", hazardStall); end
    tick();
    nCmp++;
    if (act() !== exp || oRt !== 5'd9 || oValid !== 1'b1) begin nErr++; $display("FAIL lu_rt_load: got %h want %h", act(), exp); end
  endtask
  task automatic test_zero_reg();
    loadInstr(5'd0);
    drv = rnd(31);
    drv.rs = 0;
    drv.rt = 0;
    usesRt = 1;
    #1;
    nCmp++;
    if (hazardStall !== 1'b0) begin nErr++; $display("FAIL zero_exempt: got %b want 0", hazardStall); end
    tick();
    nCmp++;
    if (act() !== exp) begin nErr++; $display("FAIL zero_load: got %h want %h", act(), exp); end
  endtask
  task automatic test_flush();
    loadInstr(5'd8);
    drv = rnd(31);
    drv.rs = 8;
    flush = 1;
    stall = 1;
    #1;
    nCmp++;
    if (hazardStall !== 1'b0) begin nErr++; $display("FAIL flush_hazard_gate: got %b want 0", hazardStall); end
    tick();
    nCmp++;
    if (act() !== rec_t'(0) || act() !== exp) begin nErr++; $display("FAIL flush_bubble: got %h want 0", act()); end
    flush = 0;
    stall = 0;
  endtask
  task automatic test_stall_hold();
    rec_t held;
    drv = rnd(31);
    drv.memRead = 0;
    usesRt = 0;
    tick();
    held = drv;
    held.valid = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drv = rnd(31);
      tick();
      nCmp++;
      if (act() !== held) begin nErr++; $display("FAIL stall_hold_%0d: got %h want %h", i, act(), held); end
    end
    stall = 0;
    drv = rnd(31);
    held = drv;
    held.valid = 1;
    tick();
    nCmp++;
    if (act() !== held) begin nErr++; $display("FAIL stall_release: got %h want %h", act(), held); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drv = rnd(31);
      drv.memRead = 1;
      drv.rt = 5'(10 + i);
      drv.rs = 5'(10 + i - 1);
      usesRt = 0;
      #1;
      nCmp++;
      if (hazardStall !== modelHaz()) begin nErr++; $display("FAIL b2b_hazard_%0d: got %b want %b", i, hazardStall, modelHaz()); end
      tick();
      if (!oValid) tick();
      nCmp++;
      if (act() !== exp || oRt !== 5'(10 + i)) begin nErr++; $display("FAIL b2b_load_%0d: got %h want %h", i, act(), exp); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drv = rnd(3);
      usesRt = 1'($urandom);
      rst = ($urandom_range(49) == 0);
      flush = ($urandom_range(9) == 0);
      stall = ($urandom_range(5) == 0);
      #1;
      nCmp++;
      if (hazardStall !== modelHaz()) begin nErr++; $display("FAIL rand_hazard_%0d: got %b want %b", i, hazardStall, modelHaz()); end
      tick();
      nCmp++;
      if (act() !== exp) begin nErr++; $display("FAIL rand_out_%0d: got %h want %h", i, act(), exp); end
    end
    rst = 0;
    flush = 0;
    stall = 0;
  endtask
  initial begin
    test_reset();
    test_load_use_rs();
    test_load_use_rt();
    test_zero_reg();
    test_flush();
    test_stall_hold();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register for the five-stage MIPS core, with integrated load-use hazard detection. It captures decoded control and operands from ID on each clock and presents them to EX. The registered source and destination fields drive the forwarding unit's `IDEX_RegisterRs`/`IDEX_RegisterRt` inputs. It inserts a bubble on a load-use hazard, holds on an external stall, and squashes on a branch flush.

## Interface
- `DATA_W`, 32, operand/immediate/PC width
- `REG_W`, 5, register-specifier width
- `ALUOP_W`, 3, ALU operation code width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemToReg`, `ID_ALUSrc`, `ID_RegDst`  in  1 each  decoded controls
- `ID_ALUOp`  in  ALUOP_W  ALU operation
- `ID_UsesRt`  in  1  instruction reads Rt as a source (R-type, store, branch)
- `ID_ReadData1`, `ID_ReadData2`, `ID_Imm`, `ID_PC4`  in  DATA_W each  register-file reads, sign-extended immediate, PC+4
- `ID_RegisterRs`, `ID_RegisterRt`, `ID_RegisterRd`  in  REG_W each  register specifiers
- `Flush`  in  1  branch/jump taken in EX; squash the ID instruction
- `Stall`  in  1  downstream hold (memory wait); freeze the register
- `IDEX_*`  out  same widths as `ID_*` counterparts (except `ID_UsesRt`)  registered fields
- `IDEX_Valid`  out  1  register holds a real instruction
- `HazardStall`  out  1  combinational; freezes PC and IF/ID this cycle

## Operation
- **Bubble:** all control outputs = 0, `IDEX_Valid`=0, `IDEX_RegisterRs/Rt/Rd`=0, and data fields = 0. Zero specifiers guarantee no false forward match.
- **Load-use hazard:** `HazardStall`=1 iff all of the following hold:
  - `IDEX_Valid` and `IDEX_MemRead`;
  - `IDEX_RegisterRt`≠0;
  - `IDEX_RegisterRt`==`ID_RegisterRs`, or (`ID_UsesRt` and `IDEX_RegisterRt`==`ID_RegisterRt`).
- **Per-edge update priority, highest first:**
  1. `rst` → bubble.
  2. `Flush` → bubble, regardless of `Stall` or hazard.
  3. `Stall` → hold all fields, including `IDEX_Valid`.
  4. `HazardStall` → bubble. IF/ID is frozen externally, so the consumer instruction re-presents next cycle.
  5. Otherwise → load all `ID_*` fields and set `IDEX_Valid`=1.
- `HazardStall` is not gated by `Stall`. Upstream ORs the two for the PC/IF-ID enable.
- `HazardStall` is gated by `Flush`: it is forced to 0 when `Flush`=1, because the ID instruction is being discarded.
- No arithmetic is performed. All fields pass through at their declared widths.

## Timing
- **Reset value:** every output is 0, including `IDEX_Valid`=0. `HazardStall` is 0 while the register holds a bubble.
- **Latency:** one cycle from ID inputs to `IDEX_*` outputs.
- **Load-use penalty:** exactly one bubble per hazard. On the next cycle the load is in MEM and the forwarding unit's MEM/WB path covers the dependency.
- **Back-to-back loads:** each load-use pair costs one bubble. A bubble never triggers a hazard because `IDEX_Valid`=0.
- **Reset mid-stall:** reset wins on the same edge and clears `HazardStall` on the following cycle.
- **`Stall` held for N cycles:** outputs are identical for all N cycles. The hazard is re-evaluated each cycle from the held values.

## Configuration
- `LOAD_USE_STALL_EN`
  - **Defined:** hazard detection as specified above.
  - **Undefined:** `HazardStall` is tied to 0 and no hazard bubbles are inserted. The toolchain is responsible for scheduling a NOP after every load. `Flush` and `Stall` behaviour is unchanged.

## Structure
- **Shared package `pipe_pkg`:**
  - `idex_ctrl_t` packed struct holding RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst and ALUOp.
  - `IDEX_CTRL_BUBBLE` constant (all zeros).
  - `REG_W`, `DATA_W` and `ALUOP_W` defaults.
- **Sub-module `load_use_detector`:** purely combinational, producing `HazardStall` from the ID and IDEX fields. It is instantiated only under `LOAD_USE_STALL_EN`.

## Test plan
- **Reset and pass-through:** assert `rst` for 2 cycles, then release with `ID_RegWrite`=1, `ID_RegisterRd`=5, `ID_ReadData1`=0x1234.
  - Expected: all outputs 0 during reset; next edge gives `IDEX_RegWrite`=1, `IDEX_RegisterRd`=5, `IDEX_ReadData1`=0x1234, `IDEX_Valid`=1.
- **Load-use on Rs:** `lw $8` in IDEX, ID presents Rs=8.
  - Expected: `HazardStall`=1; next cycle the outputs are a bubble and `HazardStall`=0; the following edge loads the consumer.
- **Load-use on Rt, with and without `ID_UsesRt`:** `lw $9` in IDEX, ID Rt=9.
  - Expected: `ID_UsesRt`=1 → `HazardStall`=1; `ID_UsesRt`=0 → `HazardStall`=0.
- **$zero exemption:** `lw $0` in IDEX, ID Rs=0.
  - Expected: `HazardStall`=0.
- **Flush dominance:** `Flush`=1 together with `Stall`=1 and a pending hazard.
  - Expected: next cycle is a bubble, `IDEX_Valid`=0, and `HazardStall`=0 during the flush cycle.
- **Stall hold:** `Stall`=1 for 3 cycles while ID inputs change every cycle.
  - Expected: `IDEX_*` outputs are unchanged; after release the outputs take the ID values present on the release edge.
